// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract controller: one 32-bit carry-skip adder is
// reused over WORDS cycles, least-significant slice first, carry registered.
module carry_skip_32bit_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic       blk_c;
    logic       rip_c;
    logic       blk_p;
    logic       p_bit;

    // Eight 4-bit ripple blocks; a block whose bits all propagate lets its
    // carry-in bypass the ripple chain.
    always_comb begin
        sum   = '0;
        blk_c = cin;
        rip_c = 1'b0;
        blk_p = 1'b0;
        p_bit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rip_c = blk_c;
            blk_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
                p_bit          = a[4*k+j] ^ b[4*k+j];
                sum[4*k+j]     = p_bit ^ rip_c;
                rip_c          = (a[4*k+j] & b[4*k+j]) | (p_bit & rip_c);
                blk_p          = blk_p & p_bit;
            end
            blk_c = blk_p ? blk_c : rip_c;
        end
        cout = blk_c;
    end
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDS*32-1:0] a,
    input  logic [WORDS*32-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDS*32-1:0] sum,
    output logic                cout,
    output logic                busy
);
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    idx;
    logic                carry;
    logic [WORDS*32-1:0] opa;
    logic [WORDS*32-1:0] opb;
    logic [31:0]         slice_a;
    logic [31:0]         slice_b;
    logic [31:0]         slice_sum;
    logic                slice_cout;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    assign slice_a = opa[32*idx +: 32];
    assign slice_b = opb[32*idx +: 32];

    carry_skip_32bit_adder u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~borrow_in.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[32*idx +: 32] <= slice_sum;
                    carry             <= slice_cout;
                    if (idx == CNT_W'(WORDS - 1)) begin
                        cout  <= slice_cout;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
